// File: rtl/vga_sync_decoder.sv
// Recovers pixel timing from raw VGA hs/vs: measures line/frame periods, locks
// once two consecutive clean frames match, and generates de/x/y from the counters.
//
// state     | meaning
// S_SEARCH  | waiting for a vs event to start measuring
// S_MEASURE | checking line periods and frame line count for stability
// S_LOCKED  | timing stable; de/x/y valid, any deviation drops lock with err
`timescale 1ns/1ps
module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_START  = 144,
  parameter int V_ACTIVE = 480,
  parameter int V_START  = 35
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        de,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic        err
);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [11:0] H_LO = 12'(H_START);
  localparam logic [11:0] H_HI = 12'(H_START + H_ACTIVE);
  localparam logic [11:0] V_LO = 12'(V_START);
  localparam logic [11:0] V_HI = 12'(V_START + V_ACTIVE);

  state_t      r_state, w_state_nxt;
  logic        r_hs_s1, r_hs_s2, r_hs_d;
  logic        r_vs_s1, r_vs_s2, r_vs_d;
  logic [10:0] r_hcnt, r_lcnt, r_h_total, r_v_total, r_ref_h;
  logic        r_h_seen, r_v_seen, r_ref_ok, r_bad, r_vt_ok, r_err;
  logic [10:0] w_ref_h_nxt;
  logic        w_ref_ok_nxt, w_bad_nxt, w_vt_ok_nxt, w_err_nxt;
  logic        w_hs_fall, w_vs_fall, w_period_ok, w_h_timeout;
  logic [10:0] w_hcnt_inc;
  logic        w_h_act, w_v_act;

  assign w_hs_fall   = r_hs_d & ~r_hs_s2;
  assign w_vs_fall   = r_vs_d & ~r_vs_s2;
  assign w_hcnt_inc  = r_hcnt + 11'd1;
  // A period is only meaningful if a previous hs was seen and hcnt never saturated.
  assign w_period_ok = w_hs_fall && r_h_seen && (r_hcnt != CNT_MAX);
  assign w_h_timeout = !w_hs_fall && (r_hcnt == CNT_MAX - 11'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs_s1   <= 1'b1;
      r_hs_s2   <= 1'b1;
      r_hs_d    <= 1'b1;
      r_vs_s1   <= 1'b1;
      r_vs_s2   <= 1'b1;
      r_vs_d    <= 1'b1;
      r_hcnt    <= '0;
      r_lcnt    <= '0;
      r_h_total <= '0;
      r_v_total <= '0;
      r_h_seen  <= 1'b0;
      r_v_seen  <= 1'b0;
      r_state   <= S_SEARCH;
      r_ref_h   <= '0;
      r_ref_ok  <= 1'b0;
      r_bad     <= 1'b0;
      r_vt_ok   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_hs_s1 <= hs_in;
      r_hs_s2 <= r_hs_s1;
      r_hs_d  <= r_hs_s2;
      r_vs_s1 <= vs_in;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;

      if (w_hs_fall)              r_hcnt <= '0;
      else if (r_hcnt != CNT_MAX) r_hcnt <= w_hcnt_inc;
      if (w_hs_fall)   r_h_seen  <= 1'b1;
      if (w_period_ok) r_h_total <= w_hcnt_inc;

      // A coincident hs belongs to the new frame, so it restarts lcnt at 1.
      if (w_vs_fall)                            r_lcnt <= w_hs_fall ? 11'd1 : 11'd0;
      else if (w_hs_fall && r_lcnt != CNT_MAX) r_lcnt <= r_lcnt + 11'd1;
      if (w_vs_fall) begin
        r_v_seen <= 1'b1;
        if (r_v_seen) r_v_total <= r_lcnt;
      end

      r_state  <= w_state_nxt;
      r_ref_h  <= w_ref_h_nxt;
      r_ref_ok <= w_ref_ok_nxt;
      r_bad    <= w_bad_nxt;
      r_vt_ok  <= w_vt_ok_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ref_h_nxt  = r_ref_h;
    w_ref_ok_nxt = r_ref_ok;
    w_bad_nxt    = r_bad;
    w_vt_ok_nxt  = r_vt_ok;
    w_err_nxt    = w_h_timeout;
    unique case (r_state)
      S_SEARCH: begin
        if (w_vs_fall) begin
          w_state_nxt  = S_MEASURE;
          w_ref_ok_nxt = 1'b0;
          w_bad_nxt    = 1'b0;
          w_vt_ok_nxt  = 1'b0;
        end
      end
      S_MEASURE: begin
        if (w_h_timeout) begin
          w_state_nxt = S_SEARCH;
        end else begin
          if (w_period_ok) begin
            w_ref_h_nxt  = w_hcnt_inc;
            w_ref_ok_nxt = 1'b1;
            if (r_ref_ok && (w_hcnt_inc != r_ref_h)) w_bad_nxt = 1'b1;
          end
          // r_vt_ok means r_v_total holds a count measured while measuring.
          if (w_vs_fall) begin
            if (!w_bad_nxt && r_ref_ok && r_vt_ok && (r_lcnt == r_v_total))
              w_state_nxt = S_LOCKED;
            w_vt_ok_nxt = 1'b1;
            w_bad_nxt   = 1'b0;
          end
        end
      end
      S_LOCKED: begin
        if (w_h_timeout || (w_period_ok && (w_hcnt_inc != r_ref_h)) ||
            (w_vs_fall && (r_lcnt != r_v_total))) begin
          w_state_nxt = S_SEARCH;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = S_SEARCH;
    endcase
  end

  assign w_h_act = ({1'b0, r_hcnt} >= H_LO) && ({1'b0, r_hcnt} < H_HI);
  assign w_v_act = ({1'b0, r_lcnt} >= V_LO) && ({1'b0, r_lcnt} < V_HI);
  assign locked  = (r_state == S_LOCKED);
  assign de      = locked && w_h_act && w_v_act;
  assign x       = de ? (r_hcnt - H_LO[10:0]) : 11'd0;
  assign y       = de ? (r_lcnt - V_LO[10:0]) : 11'd0;
  assign h_total = r_h_total;
  assign v_total = r_v_total;
  assign err     = r_err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder using a reduced 100x25 raster so that
// lock, fault, timeout, coincident-sync and reset scenarios fit a short run.
`timescale 1ns/1ps
module tb_vga_sync_decoder;
  localparam int HA = 64, HS = 20, VA = 18, VS = 3;
  localparam int LINE = 100, NL = 25, HSW = 12;
  localparam int DE_FRAME = HA * VA;

  localparam int S_LOCKED = 0, S_HTOT = 1, S_VTOT = 2, S_DE = 3, S_X = 4, S_Y = 5,
                 S_ERR = 6, S_ERRCNT = 7, S_DECNT = 8, S_FX = 9, S_FY = 10,
                 S_LX = 11, S_LY = 12, S_ERRH = 13, S_HCNT = 14, S_LCNT = 15;

  logic        clk = 1'b0, rst, hs_in, vs_in;
  logic [10:0] x, y, h_total, v_total;
  logic        de, locked, err;

  vga_sync_decoder #(.H_ACTIVE(HA), .H_START(HS), .V_ACTIVE(VA), .V_START(VS)) dut (
    .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in),
    .x(x), .y(y), .de(de), .locked(locked),
    .h_total(h_total), .v_total(v_total), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_bad = 0;
  bit   probe_req = 1'b0;
  int   err_cnt = 0, de_cnt = 0, fx = -1, fy = -1, lx = -1, ly = -1, err_h = -1;
  bit   seen_de = 1'b0;

  function automatic int actual(int s);
    case (s)
      S_LOCKED: return int'(locked);
      S_HTOT:   return int'(h_total);
      S_VTOT:   return int'(v_total);
      S_DE:     return int'(de);
      S_X:      return int'(x);
      S_Y:      return int'(y);
      S_ERR:    return int'(err);
      S_ERRCNT: return err_cnt;
      S_DECNT:  return de_cnt;
      S_FX:     return fx;
      S_FY:     return fy;
      S_LX:     return lx;
      S_LY:     return ly;
      S_ERRH:   return err_h;
      S_HCNT:   return int'(dut.r_hcnt);
      S_LCNT:   return int'(dut.r_lcnt);
      default:  return -1;
    endcase
  endfunction

  // Monitor: accumulates err/de activity and drains the scoreboard on a probe.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (err) begin
      err_cnt++;
      err_h = int'(dut.r_hcnt);
    end
    if (de) begin
      if (!seen_de) begin
        fx = int'(x);
        fy = int'(y);
        seen_de = 1'b1;
      end
      lx = int'(x);
      ly = int'(y);
      de_cnt++;
    end
    if (probe_req) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        a = actual(e.sel);
        n_vec++;
        if (a != e.val) begin
          n_bad++;
          $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, a, e.val, $time);
        end
      end
      err_cnt = 0; de_cnt = 0; seen_de = 1'b0;
      fx = -1; fy = -1; lx = -1; ly = -1;
      probe_req = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(string n, int s, int v);
    exp_t e;
    e.name = n; e.sel = s; e.val = v;
    q.push_back(e);
  endtask

  task automatic probe();
    probe_req = 1'b1;
    @(negedge clk);
    #1;
    if (probe_req) begin
      n_vec++;
      n_bad++;
      $display("FAIL probe_timeout: monitor did not service probe, pending %0d", q.size());
      q.delete();
      probe_req = 1'b0;
    end
  endtask

  task automatic run_line(int len, int vf, int vr);
    for (int c = 0; c < len; c++) begin
      hs_in = (c >= HSW);
      if (c == vf) vs_in = 1'b0;
      if (c == vr) vs_in = 1'b1;
      tick();
    end
  endtask

  task automatic frame_part(int l0, int l1, int vpos, int short_idx);
    for (int l = l0; l < l1; l++)
      run_line((l == short_idx) ? LINE - 1 : LINE, (l == 0) ? vpos : -1, (l == 2) ? vpos : -1);
  endtask

  task automatic idle(int n);
    hs_in = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    repeat (3) tick();
    ex("rst_locked", S_LOCKED, 0); ex("rst_htot", S_HTOT, 0); ex("rst_vtot", S_VTOT, 0);
    ex("rst_de", S_DE, 0); ex("rst_x", S_X, 0); ex("rst_y", S_Y, 0); ex("rst_err", S_ERR, 0);
    ex("rst_hcnt", S_HCNT, 0); ex("rst_lcnt", S_LCNT, 0);
    probe();
    rst = 1'b1;

    // Initial acquisition: lock rises on the third vs event.
    repeat (3) frame_part(0, NL, 40, -1);
    ex("acq_locked", S_LOCKED, 1); ex("acq_htot", S_HTOT, LINE); ex("acq_vtot", S_VTOT, NL);
    ex("acq_errcnt", S_ERRCNT, 0); ex("acq_decnt", S_DECNT, DE_FRAME);
    ex("acq_fx", S_FX, 0); ex("acq_fy", S_FY, 0); ex("acq_lx", S_LX, HA - 1); ex("acq_ly", S_LY, VA - 1);
    probe();

    frame_part(0, NL, 40, -1);
    ex("steady_locked", S_LOCKED, 1); ex("steady_decnt", S_DECNT, DE_FRAME);
    ex("steady_errcnt", S_ERRCNT, 0); ex("steady_vtot", S_VTOT, NL);
    probe();

    // Line 10 shortened by one clock.
    frame_part(0, 12, 40, 10);
    ex("short_htot", S_HTOT, LINE - 1); ex("short_locked", S_LOCKED, 0);
    ex("short_errcnt", S_ERRCNT, 1); ex("short_decnt", S_DECNT, 8 * HA);
    ex("short_lx", S_LX, HA - 1); ex("short_ly", S_LY, 7);
    probe();
    frame_part(12, 13, 40, -1);
    ex("after_short_htot", S_HTOT, LINE); ex("after_short_locked", S_LOCKED, 0);
    ex("after_short_errcnt", S_ERRCNT, 0);
    probe();
    frame_part(13, NL, 40, -1);
    repeat (2) frame_part(0, NL, 40, -1);
    ex("relock_wait_locked", S_LOCKED, 0); ex("relock_wait_errcnt", S_ERRCNT, 0);
    ex("relock_wait_decnt", S_DECNT, 0); ex("relock_wait_vtot", S_VTOT, NL);
    probe();
    frame_part(0, 1, 40, -1);
    ex("relock_locked", S_LOCKED, 1); ex("relock_errcnt", S_ERRCNT, 0);
    probe();
    frame_part(1, NL, 40, -1);
    ex("relock_decnt", S_DECNT, DE_FRAME); ex("relock_fx", S_FX, 0); ex("relock_fy", S_FY, 0);
    ex("relock_lx", S_LX, HA - 1); ex("relock_ly", S_LY, VA - 1); ex("relock_locked2", S_LOCKED, 1);
    probe();

    // Move vs onto the hs edge; the 26-line frame keeps the hs count at 25.
    frame_part(0, NL + 1, 40, -1);
    frame_part(0, 1, 0, -1);
    ex("coinc_locked", S_LOCKED, 1); ex("coinc_vtot", S_VTOT, NL);
    ex("coinc_lcnt", S_LCNT, 1); ex("coinc_errcnt", S_ERRCNT, 0);
    probe();
    frame_part(1, NL, 0, -1);
    ex("coinc_decnt", S_DECNT, DE_FRAME); ex("coinc_fx", S_FX, 0); ex("coinc_fy", S_FY, 0);
    ex("coinc_lx", S_LX, HA - 1); ex("coinc_ly", S_LY, VA - 1); ex("coinc_locked2", S_LOCKED, 1);
    probe();
    frame_part(0, NL, 0, -1);
    ex("coinc2_locked", S_LOCKED, 1); ex("coinc2_vtot", S_VTOT, NL); ex("coinc2_errcnt", S_ERRCNT, 0);
    probe();

    // hs stuck high.
    idle(3000);
    ex("tmo_errcnt", S_ERRCNT, 1); ex("tmo_err_hcnt", S_ERRH, 2047);
    ex("tmo_locked", S_LOCKED, 0); ex("tmo_htot", S_HTOT, LINE); ex("tmo_hcnt", S_HCNT, 2047);
    probe();

    // Reacquire, then reset in the middle of an active line.
    repeat (3) frame_part(0, NL, 0, -1);
    frame_part(0, 10, 0, -1);
    run_line(50, -1, -1);
    ex("pre_rst_locked", S_LOCKED, 1); ex("pre_rst_de", S_DE, 1);
    ex("pre_rst_x", S_X, 27); ex("pre_rst_y", S_Y, 8);
    probe();
    tick();
    rst = 1'b0;
    ex("mid_rst_locked", S_LOCKED, 0); ex("mid_rst_htot", S_HTOT, 0); ex("mid_rst_vtot", S_VTOT, 0);
    ex("mid_rst_de", S_DE, 0); ex("mid_rst_x", S_X, 0); ex("mid_rst_y", S_Y, 0);
    ex("mid_rst_err", S_ERR, 0); ex("mid_rst_hcnt", S_HCNT, 0); ex("mid_rst_lcnt", S_LCNT, 0);
    probe();
    repeat (2) tick();
    rst = 1'b1;
    idle(47);
    frame_part(11, NL, 0, -1);
    repeat (2) frame_part(0, NL, 0, -1);
    ex("post_rst_locked", S_LOCKED, 0); ex("post_rst_errcnt", S_ERRCNT, 0); ex("post_rst_decnt", S_DECNT, 0);
    probe();
    frame_part(0, 1, 0, -1);
    ex("post_rst_relock", S_LOCKED, 1); ex("post_rst_htot", S_HTOT, LINE); ex("post_rst_vtot", S_VTOT, NL);
    probe();
    frame_part(1, NL, 0, -1);
    ex("post_rst_decnt2", S_DECNT, DE_FRAME); ex("post_rst_ly", S_LY, VA - 1);
    ex("post_rst_errcnt2", S_ERRCNT, 0);
    probe();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
